// File: rtl/mdu_pkg.sv
// Shared types and default latencies for the execute-stage multiply/divide unit.
// Optional MADD/MADDU/MSUB/MSUBU support is enabled by defining MDU_MADD_EN.
package mdu_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8,
    MD_MADD  = 4'd9,
    MD_MADDU = 4'd10,
    MD_MSUB  = 4'd11,
    MD_MSUBU = 4'd12
  } md_op_t;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;

  // Two's-complement negation when the operand is treated as signed and negative.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath: forms the 64-bit {HI,LO} value an MD op will write and its write-enable.
// MDU_MADD_EN adds the multiply-accumulate/subtract ops; otherwise op codes 9..12 fall to NONE.
import mdu_pkg::*;

module mdu_arith (
  input  md_op_t      op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] result,
  output logic        we
);

  logic        sgn_mul;
  logic        sgn_div;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] product;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [31:0] quot_mag;
  logic [31:0] rem_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  always_comb begin
    sgn_mul = (op == MD_MULT) || (op == MD_MADD) || (op == MD_MSUB);
    sgn_div = (op == MD_DIV);

    // Sign-extending to 64 bits makes the low 64 product bits correct for signed ops.
    mul_a   = {{32{sgn_mul & rs[31]}}, rs};
    mul_b   = {{32{sgn_mul & rt[31]}}, rt};
    product = mul_a * mul_b;

    // Divide on magnitudes, then restore signs; 0x80000000/-1 naturally wraps to 0x80000000 rem 0.
    div_a    = mag32(rs, sgn_div);
    div_b    = mag32(rt, sgn_div);
    quot_mag = (div_b == 32'd0) ? 32'd0 : (div_a / div_b);
    rem_mag  = (div_b == 32'd0) ? 32'd0 : (div_a % div_b);
    quot     = (sgn_div && (rs[31] ^ rt[31])) ? (~quot_mag + 32'd1) : quot_mag;
    rem      = (sgn_div && rs[31]) ? (~rem_mag + 32'd1) : rem_mag;

    result = 64'd0;
    we     = 1'b0;
    case (op)
      MD_MULT, MD_MULTU: begin
        result = product;
        we     = 1'b1;
      end
      MD_DIV, MD_DIVU: begin
        result = {rem, quot};
        we     = (rt != 32'd0);
      end
      MD_MTHI: begin
        result = {rs, lo};
        we     = 1'b1;
      end
      MD_MTLO: begin
        result = {hi, rs};
        we     = 1'b1;
      end
`ifdef MDU_MADD_EN
      MD_MADD, MD_MADDU: begin
        result = {hi, lo} + product;
        we     = 1'b1;
      end
      MD_MSUB, MD_MSUBU: begin
        result = {hi, lo} - product;
        we     = 1'b1;
      end
`endif
      default: begin
        result = 64'd0;
        we     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: holds HI/LO, models MULT/DIV latency with a busy counter.
// Define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU (multi-cycle, MULT latency).
import mdu_pkg::*;

module e_mdu #(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] mu_result,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_op_t             op;
  logic [63:0]        arith_result;
  logic               arith_we;
  logic               is_mult;
  logic               is_div;
  logic               is_mt;

  logic [CNT_W-1:0]   cnt_reg,     cnt_next;
  logic               busy_reg,    busy_next;
  logic [63:0]        pend_reg,    pend_next;
  logic               pend_we_reg, pend_we_next;
  logic [31:0]        hi_reg,      hi_next;
  logic [31:0]        lo_reg,      lo_next;

  assign op = md_op_t'(md_op);

  mdu_arith u_arith (
    .op     (op),
    .rs     (rs_val),
    .rt     (rt_val),
    .hi     (hi_reg),
    .lo     (lo_reg),
    .result (arith_result),
    .we     (arith_we)
  );

  always_comb begin
    is_mult = (op == MD_MULT) || (op == MD_MULTU);
`ifdef MDU_MADD_EN
    is_mult = is_mult || (op == MD_MADD) || (op == MD_MADDU) ||
              (op == MD_MSUB) || (op == MD_MSUBU);
`endif
    is_div  = (op == MD_DIV) || (op == MD_DIVU);
    is_mt   = (op == MD_MTHI) || (op == MD_MTLO);
  end

  always_comb begin
    cnt_next     = cnt_reg;
    pend_next    = pend_reg;
    pend_we_next = pend_we_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;

    // A start arriving while busy is dropped; this also makes a commit win over MTHI/MTLO.
    if (cnt_reg != '0) begin
      cnt_next = cnt_reg - CNT_W'(1);
      if (cnt_reg == CNT_W'(1)) begin
        pend_we_next = 1'b0;
        if (pend_we_reg) begin
          hi_next = pend_reg[63:32];
          lo_next = pend_reg[31:0];
        end
      end
    end else if (start) begin
      if (is_mult || is_div) begin
        cnt_next     = is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        pend_next    = arith_result;
        pend_we_next = arith_we;
      end else if (is_mt && arith_we) begin
        hi_next = arith_result[63:32];
        lo_next = arith_result[31:0];
      end
    end

    busy_next = (cnt_next != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg     <= '0;
      busy_reg    <= 1'b0;
      pend_reg    <= 64'd0;
      pend_we_reg <= 1'b0;
      hi_reg      <= 32'd0;
      lo_reg      <= 32'd0;
    end else begin
      cnt_reg     <= cnt_next;
      busy_reg    <= busy_next;
      pend_reg    <= pend_next;
      pend_we_reg <= pend_we_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
    end
  end

  always_comb begin
    case (op)
      MD_MFHI: mu_result = hi_reg;
      MD_MFLO: mu_result = lo_reg;
      default: mu_result = 32'd0;
    endcase
  end

  assign busy = busy_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_e_mdu.sv
// Directed self-checking bench for e_mdu; expectations are hand-computed per vector.
// MADD checks follow MDU_MADD_EN, which must match the RTL build.
module tb_e_mdu;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam int NMUL = 5;
  localparam int NDIV = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  md_op = 4'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        busy;
  logic [31:0] mu_result;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  always #5 clk = ~clk;

  e_mdu dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .md_op     (md_op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .busy      (busy),
    .mu_result (mu_result),
    .hi        (hi),
    .lo        (lo)
  );

  // The hazard unit must never issue an MD op while one is in flight.
  always @(posedge clk)
    if (reset && start && busy) $error("start asserted while busy");

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; md_op = op; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0; md_op = OP_NONE;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    md_op = OP_MFHI; #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi: got %h want 00000000", hi); end
    total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo: got %h want 00000000", lo); end
    total++; if (mu_result !== 32'd0) begin bad++; $display("FAIL reset_mfhi: got %h want 00000000", mu_result); end
    md_op = OP_NONE;
    reset = 1'b1;
    $display("reset: busy=%b hi=%h lo=%h", busy, hi, lo);
  endtask

  task automatic test_mult;
    logic [3:0]  ops [2] = '{OP_MULT, OP_MULTU};
    logic [31:0] va  [2] = '{32'hFFFFFFFE, 32'hFFFFFFFF};
    logic [31:0] vb  [2] = '{32'h00000003, 32'hFFFFFFFF};
    logic [31:0] eh  [2] = '{32'hFFFFFFFF, 32'hFFFFFFFE};
    logic [31:0] el  [2] = '{32'hFFFFFFFA, 32'h00000001};
    for (int v = 0; v < 2; v++) begin
      issue(ops[v], va[v], vb[v]);
      for (int c = 1; c <= NMUL; c++) begin
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mult%0d_busy_c%0d: got %b want 1", v, c, busy); end
        total++; if ({hi, lo} !== {exp_hi, exp_lo}) begin bad++; $display("FAIL mult%0d_early_c%0d: got %h%h want %h%h", v, c, hi, lo, exp_hi, exp_lo); end
        @(negedge clk);
      end
      exp_hi = eh[v]; exp_lo = el[v];
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL mult%0d_done_busy: got %b want 0", v, busy); end
      total++; if (hi !== exp_hi) begin bad++; $display("FAIL mult%0d_hi: got %h want %h", v, hi, exp_hi); end
      total++; if (lo !== exp_lo) begin bad++; $display("FAIL mult%0d_lo: got %h want %h", v, lo, exp_lo); end
      $display("mult op=%0d rs=%h rt=%h -> hi=%h lo=%h", ops[v], va[v], vb[v], hi, lo);
    end
  endtask

  task automatic test_div;
    logic [3:0]  ops  [5] = '{OP_DIV, OP_DIV, OP_DIV, OP_DIVU, OP_DIVU};
    logic [31:0] va   [5] = '{32'hFFFFFFF9, 32'h00000007, 32'h80000000, 32'hFFFFFFFF, 32'h00000007};
    logic [31:0] vb   [5] = '{32'h00000002, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000010, 32'h00000000};
    logic [31:0] eh   [5] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0000000F, 32'h0000000F};
    logic [31:0] el   [5] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'h0FFFFFFF, 32'h0FFFFFFF};
    for (int v = 0; v < 5; v++) begin
      issue(ops[v], va[v], vb[v]);
      for (int c = 1; c <= NDIV; c++) begin
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL div%0d_busy_c%0d: got %b want 1", v, c, busy); end
        total++; if ({hi, lo} !== {exp_hi, exp_lo}) begin bad++; $display("FAIL div%0d_early_c%0d: got %h%h want %h%h", v, c, hi, lo, exp_hi, exp_lo); end
        @(negedge clk);
      end
      exp_hi = eh[v]; exp_lo = el[v];
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL div%0d_done_busy: got %b want 0", v, busy); end
      total++; if (hi !== exp_hi) begin bad++; $display("FAIL div%0d_hi: got %h want %h", v, hi, exp_hi); end
      total++; if (lo !== exp_lo) begin bad++; $display("FAIL div%0d_lo: got %h want %h", v, lo, exp_lo); end
      $display("div op=%0d rs=%h rt=%h -> hi=%h lo=%h", ops[v], va[v], vb[v], hi, lo);
    end
  endtask

  task automatic test_mt_mf;
    issue(OP_MTHI, 32'h00001234, 32'hDEADBEEF);
    exp_hi = 32'h00001234;
    md_op = OP_MFHI; #1;
    total++; if (mu_result !== 32'h00001234) begin bad++; $display("FAIL mfhi: got %h want 00001234", mu_result); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mthi_busy: got %b want 0", busy); end
    $display("mthi 00001234 -> mfhi=%h busy=%b", mu_result, busy);
    issue(OP_MTLO, 32'h00005678, 32'h0);
    exp_lo = 32'h00005678;
    total++; if (lo !== exp_lo) begin bad++; $display("FAIL mtlo_lo: got %h want %h", lo, exp_lo); end
    total++; if (hi !== exp_hi) begin bad++; $display("FAIL mtlo_hi: got %h want %h", hi, exp_hi); end
    md_op = OP_MFLO; #1;
    total++; if (mu_result !== 32'h00005678) begin bad++; $display("FAIL mflo: got %h want 00005678", mu_result); end
    md_op = OP_MULT; #1;
    total++; if (mu_result !== 32'd0) begin bad++; $display("FAIL mu_other_op: got %h want 00000000", mu_result); end
    md_op = OP_NONE;
    $display("mtlo 00005678 -> lo=%h", lo);
  endtask

  task automatic test_madd;
    issue(OP_MTHI, 32'h0, 32'h0);
    issue(OP_MTLO, 32'hFFFFFFFF, 32'h0);
    exp_hi = 32'h0; exp_lo = 32'hFFFFFFFF;
    issue(OP_MADDU, 32'd1, 32'd1);
    for (int c = 1; c <= NMUL; c++) begin
`ifdef MDU_MADD_EN
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL madd_busy_c%0d: got %b want 1", c, busy); end
`else
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL madd_off_busy_c%0d: got %b want 0", c, busy); end
`endif
      total++; if ({hi, lo} !== {exp_hi, exp_lo}) begin bad++; $display("FAIL madd_early_c%0d: got %h%h want %h%h", c, hi, lo, exp_hi, exp_lo); end
      @(negedge clk);
    end
`ifdef MDU_MADD_EN
    exp_hi = 32'h1; exp_lo = 32'h0;
`endif
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL madd_done_busy: got %b want 0", busy); end
    total++; if (hi !== exp_hi) begin bad++; $display("FAIL madd_hi: got %h want %h", hi, exp_hi); end
    total++; if (lo !== exp_lo) begin bad++; $display("FAIL madd_lo: got %h want %h", lo, exp_lo); end
    $display("maddu 1*1 -> hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_back_to_back;
    issue(OP_MULT, 32'd3, 32'd4);
    repeat (NMUL) @(negedge clk);
    exp_hi = 32'h0; exp_lo = 32'hC;
    total++; if ({busy, hi, lo} !== {1'b0, exp_hi, exp_lo}) begin bad++; $display("FAIL b2b_mult: got %b %h %h want 0 %h %h", busy, hi, lo, exp_hi, exp_lo); end
    $display("mult 3*4 -> hi=%h lo=%h", hi, lo);
    // Issue the divide in the very cycle the multiply result became visible.
    start = 1'b1; md_op = OP_DIVU; rs_val = 32'd100; rt_val = 32'd7;
    @(negedge clk);
    start = 1'b0; md_op = OP_NONE;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_div_busy: got %b want 1", busy); end
    repeat (NDIV) @(negedge clk);
    exp_hi = 32'd2; exp_lo = 32'd14;
    total++; if ({busy, hi, lo} !== {1'b0, exp_hi, exp_lo}) begin bad++; $display("FAIL b2b_divu: got %b %h %h want 0 %h %h", busy, hi, lo, exp_hi, exp_lo); end
    $display("divu 100/7 -> hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_reset_mid;
    issue(OP_DIV, 32'd100, 32'd3);
    repeat (2) @(negedge clk);
    reset = 1'b0; #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    total++; if ({hi, lo} !== 64'd0) begin bad++; $display("FAIL rstmid_hilo: got %h%h want 0", hi, lo); end
    @(negedge clk);
    reset = 1'b1;
    repeat (NDIV + 2) @(negedge clk);
    exp_hi = 32'd0; exp_lo = 32'd0;
    total++; if ({busy, hi, lo} !== {1'b0, exp_hi, exp_lo}) begin bad++; $display("FAIL rstmid_nocommit: got %b %h %h want 0 0 0", busy, hi, lo); end
    $display("reset mid-div -> busy=%b hi=%h lo=%h", busy, hi, lo);
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_mt_mf;
    test_madd;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
